// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op encodings, FSM state type and iteration count.
package mdu_pkg;

    localparam logic [1:0] MDU_MULTU = 2'b00;
    localparam logic [1:0] MDU_MULT  = 2'b01;
    localparam logic [1:0] MDU_DIVU  = 2'b10;
    localparam logic [1:0] MDU_DIV   = 2'b11;

    localparam int MDU_ITER = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// One iteration: shift-add multiply or restoring-divide step
// on a 2*DATA_W accumulator.
module mdu_step #(
    parameter int DATA_W = 32
) (
    input  logic                is_div,
    input  logic [2*DATA_W-1:0] acc,
    input  logic [DATA_W-1:0]   operand,
    output logic [2*DATA_W-1:0] acc_next
);

    logic [DATA_W:0]   mul_sum;
    logic [DATA_W+1:0] div_diff;

    always_comb begin
        mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]};
        if (acc[0]) begin
            mul_sum = mul_sum + {1'b0, operand};
        end
        // Shifted partial remainder is DATA_W+1 bits; an extra bit catches the borrow.
        div_diff = {1'b0, acc[2*DATA_W-1:DATA_W-1]} - {2'b00, operand};
        acc_next = {mul_sum, acc[DATA_W-1:1]};
        if (is_div) begin
            if (!div_diff[DATA_W+1]) begin
                acc_next = {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*DATA_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One result bit per cycle; signs handled by magnitude + final fix-up.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic              hi_we_i,
    input  logic              lo_we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = $clog2(MDU_ITER);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MDU_ITER - 1);

    mdu_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic                is_div_q;
    logic                neg_lo_q;
    logic                neg_hi_q;
    logic                dz_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] acc_n;

    logic                is_signed;
    logic                s1_neg;
    logic                s2_neg;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;

    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   res_hi;
    logic [DATA_W-1:0]   res_lo;

    always_comb begin
        is_signed = (op_i == MDU_MULT) || (op_i == MDU_DIV);
        s1_neg    = is_signed && src1_i[DATA_W-1];
        s2_neg    = is_signed && src2_i[DATA_W-1];
        a_mag     = s1_neg ? -src1_i : src1_i;
        b_mag     = s2_neg ? -src2_i : src2_i;
    end

    mdu_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .is_div   (is_div_q),
        .acc      (acc_q),
        .operand  (b_q),
        .acc_next (acc_n)
    );

    always_comb begin
        prod   = neg_lo_q ? -acc_n : acc_n;
        quo    = acc_n[DATA_W-1:0];
        rem    = acc_n[2*DATA_W-1:DATA_W];
        quo    = neg_lo_q ? -quo : quo;
        rem    = neg_hi_q ? -rem : rem;
        res_hi = prod[2*DATA_W-1:DATA_W];
        res_lo = prod[DATA_W-1:0];
        if (is_div_q) begin
            res_hi = rem;
            res_lo = quo;
            // Zero divisor reports the raw dividend, not the sign-fixed one.
            if (dz_q) begin
                res_hi = a_q;
                res_lo = '1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            cnt      <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            hi_o     <= '0;
            lo_o     <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
        end else begin
            done_o <= 1'b0;
            if (!busy_o && hi_we_i) begin
                hi_o <= wdata_i;
            end
            if (!busy_o && lo_we_i) begin
                lo_o <= wdata_i;
            end
            unique case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (start_i) begin
                        state    <= S_RUN;
                        busy_o   <= 1'b1;
                        cnt      <= '0;
                        is_div_q <= op_i[1];
                        neg_lo_q <= s1_neg ^ s2_neg;
                        neg_hi_q <= s1_neg;
                        dz_q     <= (src2_i == '0);
                        a_q      <= src1_i;
                        b_q      <= b_mag;
                        acc_q    <= {{DATA_W{1'b0}}, a_mag};
                    end
                end
                S_RUN: begin
                    acc_q <= acc_n;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state  <= S_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        hi_o   <= res_hi;
                        lo_o   <= res_lo;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
